// File: rtl/usb_packet_transmitter.sv
// usb_packet_transmitter
//   Device-side USB full-speed packet serializer. Sends SYNC, then the byte
//   stream LSB first, NRZI-encoded with bit stuffing, then EOP (SE0 SE0 J),
//   followed by a two-bit inter-packet gap. Each line bit lasts CLOCKS_PER_BIT
//   clocks of clock48.
//   Optional feature macro: USB_TX_CRC16_EN -- when defined, DATA-class PIDs
//   (low two bits 2'b11) get an inverted CRC16 appended after the last byte.
// Ports
//   clock48, reset_n        : clock, asynchronous active-low reset
//   tx_valid/tx_data/tx_last: byte stream in (first byte is the PID)
//   tx_ready                : byte taken when tx_valid && tx_ready
//   tx_busy                 : first-byte accept until line release
//   tx_done, tx_error       : end-of-packet pulses (error = underrun abort)
//   usb_dp_out, usb_dn_out  : D+/D- drive values
//   usb_oe                  : pad output enable
module usb_packet_transmitter #(
  parameter int unsigned CLOCKS_PER_BIT = 4
) (
  input  logic       clock48,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       usb_dp_out,
  output logic       usb_dn_out,
  output logic       usb_oe
);
  localparam int unsigned TW = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int unsigned GW = $clog2(2 * CLOCKS_PER_BIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_EOP} state_t;
  state_t state, state_d;

  logic [TW-1:0] bit_timer;
  logic [GW-1:0] gap_cnt;
  logic [2:0]    sym_idx;     // SYNC bit 0..7, EOP bit 0..2
  logic [15:0]   sh;          // bits still to send, next bit in sh[0]
  logic [3:0]    bit_idx;
  logic [2:0]    ones_cnt;
  logic          cur_last, end_pending, err_flag;
  logic          wrap, stuff_now, byte_end, data_ready;

`ifdef USB_TX_CRC16_EN
  logic [15:0] crc, crc_upd, crc_eff;
  logic        crc_en, in_crc, is_pid;

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int unsigned i = 0; i < 16; i++) r[i] = v[15 - i];
    return r;
  endfunction

  always_comb begin
    crc_upd = {crc[14:0], 1'b0} ^ ((crc[15] ^ sh[0]) ? 16'h8005 : 16'h0000);
    crc_eff = is_pid ? crc : crc_upd;
  end
`endif

  always_comb begin
    wrap      = (bit_timer == TW'(CLOCKS_PER_BIT - 1));
    stuff_now = (ones_cnt == 3'd6);
`ifdef USB_TX_CRC16_EN
    byte_end  = (bit_idx == (in_crc ? 4'd15 : 4'd7));
`else
    byte_end  = (bit_idx == 4'd7);
`endif
    // Request the next byte in the last clock before the final bit of the
    // current byte starts; a pending stuff bit pushes the request back.
    data_ready = (state == S_DATA) && wrap && !stuff_now && !end_pending &&
                 !cur_last && byte_end;
  end

  always_comb begin
    state_d  = state;
    tx_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        tx_ready = (gap_cnt == '0);
        if (tx_valid && tx_ready) state_d = S_SYNC;
      end
      S_SYNC: if (wrap && sym_idx == 3'd7) state_d = S_DATA;
      S_DATA: begin
        tx_ready = data_ready;
        if (wrap && !stuff_now && end_pending) state_d = S_EOP;
      end
      S_EOP:  if (wrap && sym_idx == 3'd2) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clock48 or negedge reset_n) begin
    if (!reset_n) begin
      bit_timer   <= '0;
      gap_cnt     <= '0;
      sym_idx     <= '0;
      sh          <= '0;
      bit_idx     <= '0;
      ones_cnt    <= '0;
      cur_last    <= 1'b0;
      end_pending <= 1'b0;
      err_flag    <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      usb_dp_out  <= 1'b1;
      usb_dn_out  <= 1'b0;
      usb_oe      <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc         <= '1;
      crc_en      <= 1'b0;
      in_crc      <= 1'b0;
      is_pid      <= 1'b0;
`endif
    end else begin
      tx_done   <= 1'b0;
      tx_error  <= 1'b0;
      bit_timer <= (state == S_IDLE || wrap) ? '0 : bit_timer + 1'b1;
      if (state == S_IDLE) begin
        if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        if (tx_valid && tx_ready) begin
          sh          <= {8'h00, tx_data};
          cur_last    <= tx_last;
          bit_idx     <= '0;
          sym_idx     <= '0;
          ones_cnt    <= 3'd1;
          end_pending <= 1'b0;
          err_flag    <= 1'b0;
          usb_dp_out  <= 1'b0;        // first SYNC bit is K
          usb_dn_out  <= 1'b1;
          usb_oe      <= 1'b1;
          tx_busy     <= 1'b1;
`ifdef USB_TX_CRC16_EN
          crc         <= '1;
          crc_en      <= (tx_data[1:0] == 2'b11);
          in_crc      <= 1'b0;
          is_pid      <= 1'b1;
`endif
        end
      end else if (wrap) begin
        if (state == S_SYNC && sym_idx != 3'd7) begin
          // K J K J K J K K: toggle on every step except the final K K
          sym_idx <= sym_idx + 1'b1;
          if (sym_idx != 3'd6) begin
            usb_dp_out <= ~usb_dp_out;
            usb_dn_out <= ~usb_dn_out;
          end
        end else if (state == S_EOP) begin
          if (sym_idx == 3'd2) begin
            usb_oe   <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b1;
            tx_error <= err_flag;
            gap_cnt  <= GW'(2 * CLOCKS_PER_BIT);
          end else begin
            sym_idx <= sym_idx + 1'b1;
            if (sym_idx == 3'd1) begin
              usb_dp_out <= 1'b1;
              usb_dn_out <= 1'b0;
            end
          end
        end else if (stuff_now) begin
          usb_dp_out <= ~usb_dp_out;
          usb_dn_out <= ~usb_dn_out;
          ones_cnt   <= '0;
        end else if (end_pending) begin
          usb_dp_out <= 1'b0;
          usb_dn_out <= 1'b0;
          sym_idx    <= '0;
        end else begin
          // Last SYNC bit boundary or data bit boundary: send sh[0].
          if (!sh[0]) begin
            usb_dp_out <= ~usb_dp_out;
            usb_dn_out <= ~usb_dn_out;
          end
          ones_cnt <= sh[0] ? ones_cnt + 1'b1 : 3'd0;
`ifdef USB_TX_CRC16_EN
          if (!in_crc) crc <= crc_eff;
`endif
          if (byte_end) begin
            bit_idx <= '0;
`ifdef USB_TX_CRC16_EN
            is_pid <= 1'b0;
            if (in_crc) end_pending <= 1'b1;
            else if (cur_last && crc_en) begin
              in_crc <= 1'b1;
              sh     <= rev16(~crc_eff);
            end else
`endif
            if (cur_last) end_pending <= 1'b1;
            else if (tx_valid) begin
              // tx_ready is high in this cycle, so this is the accept.
              sh       <= {8'h00, tx_data};
              cur_last <= tx_last;
            end else begin
              end_pending <= 1'b1;
              err_flag    <= 1'b1;
            end
          end else begin
            sh      <= {1'b0, sh[15:1]};
            bit_idx <= bit_idx + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_usb_packet_transmitter.sv
`timescale 1ns/1ps
module tb_usb_packet_transmitter;
  localparam int unsigned CPB = 4;

  logic       clock48 = 1'b0;
  logic       reset_n;
  logic       tx_valid, tx_last;
  logic [7:0] tx_data;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       usb_dp_out, usb_dn_out, usb_oe;

  always #10 clock48 = ~clock48;

  usb_packet_transmitter #(.CLOCKS_PER_BIT(CPB)) dut (
    .clock48(clock48), .reset_n(reset_n),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
    .usb_dp_out(usb_dp_out), .usb_dn_out(usb_dn_out), .usb_oe(usb_oe)
  );

  typedef struct packed {
    logic [15:0] nbits;
    logic        err;
    logic [15:0] pulses;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  exp_sym[$];
  logic [1:0]  cap[$];
  logic [1:0]  e[$];
  logic [7:0]  pkt [0:79];
  exp_t        rec;
  int          errors = 0, checks = 0, bad;
  bit          prev_oe = 0, expect_abort = 0, gap_on = 0, busy_bad = 0;
  int unsigned pulses = 0, gap_n = 0, spurious = 0, pkt_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (packet %0d): got %0h required %0h", name, pkt_no, act, exp);
    end
  endtask

  // Reference: bit list -> stuffing by run length -> NRZI levels -> line symbols.
  task automatic push_expect(input int unsigned nb, input bit underrun);
    bit          bits[$];
    bit          level;
    int unsigned run, nsym;
    logic [15:0] crc;
    nsym = 0;
    for (int unsigned i = 0; i < nb; i++)
      for (int unsigned b = 0; b < 8; b++) bits.push_back(pkt[i][b]);
`ifdef USB_TX_CRC16_EN
    if (!underrun && pkt[0][1:0] == 2'b11) begin
      crc = 16'hFFFF;
      for (int unsigned k = 8; k < nb * 8; k++)
        crc = (crc[15] ^ bits[k]) ? ({crc[14:0], 1'b0} ^ 16'h8005) : {crc[14:0], 1'b0};
      for (int unsigned k = 0; k < 16; k++) bits.push_back(~crc[15 - k]);
    end
`endif
    for (int unsigned k = 0; k < 8; k++) begin
      level = (k == 1 || k == 3 || k == 5);
      exp_sym.push_back({level, ~level});
      nsym++;
    end
    level = 1'b0;
    run = 1;
    foreach (bits[k]) begin
      if (bits[k]) run++;
      else begin level = ~level; run = 0; end
      exp_sym.push_back({level, ~level});
      nsym++;
      if (run == 6) begin
        level = ~level;
        run = 0;
        exp_sym.push_back({level, ~level});
        nsym++;
      end
    end
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b10);
    nsym += 3;
    exp_q.push_back('{nbits: 16'(nsym), err: underrun,
                      pulses: underrun ? 16'(nb) : 16'(nb - 1)});
  endtask

  task automatic wait_idle();
    int unsigned w = 0;
    while (!(tx_ready && !tx_busy) && w < 5000) begin @(negedge clock48); w++; end
    if (!(tx_ready && !tx_busy)) begin
      checks++; errors++;
      $display("FAIL idle_timeout: tx_ready=%b tx_busy=%b required 1/0", tx_ready, tx_busy);
    end
  endtask

  task automatic send_pkt(input int unsigned n, input int unsigned offer);
    bit          underrun;
    int unsigned w;
    underrun = (offer < n);
    @(negedge clock48);
    wait_idle();
    push_expect(underrun ? offer : n, underrun);
    for (int unsigned i = 0; i < offer; i++) begin
      if (i != 0) @(negedge clock48);
      tx_valid = 1'b1;
      tx_data  = pkt[i];
      tx_last  = !underrun && (i == n - 1);
      w = 0;
      while (!tx_ready && w < 4000) begin @(negedge clock48); w++; end
      if (!tx_ready) begin
        checks++; errors++;
        $display("FAIL handshake_timeout: byte %0d tx_ready=0 required 1", i);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        return;
      end
      @(posedge clock48);
    end
    @(negedge clock48);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  // Monitor: captures each oe window and compares it with the next expectation.
  always @(negedge clock48) begin
    if (usb_oe) begin
      cap.push_back({usb_dp_out, usb_dn_out});
      if (!tx_busy) busy_bad = 1;
      if (tx_busy && tx_ready) pulses++;
      if (tx_done || tx_error) spurious++;
    end else if (prev_oe) begin
      if (expect_abort) begin
        expect_abort = 0;
      end else if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_packet: %0d clocks of oe, required none", cap.size());
      end else begin
        rec = exp_q.pop_front();
        e.delete();
        for (int unsigned k = 0; k < rec.nbits; k++)
          if (exp_sym.size() != 0) e.push_back(exp_sym.pop_front());
        check("oe_clocks", cap.size(), rec.nbits * CPB);
        bad = -1;
        for (int unsigned i = 0; i < cap.size(); i++)
          if (bad < 0 && i / CPB < e.size() && cap[i] !== e[i / CPB]) bad = int'(i);
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL line_symbol (packet %0d): clock %0d got dp/dn=%b required %b",
                   pkt_no, bad, cap[bad], e[bad / CPB]);
        end
        check("tx_done_pulse", tx_done, 1'b1);
        check("tx_error_pulse", tx_error, rec.err);
        check("ready_pulses", pulses, rec.pulses);
        check("busy_during_oe", busy_bad, 1'b0);
        gap_on = 1;
        gap_n  = 0;
        pkt_no++;
      end
      cap.delete();
      pulses   = 0;
      busy_bad = 0;
    end else if (tx_done || tx_error) begin
      spurious++;
    end
    if (gap_on) begin
      if (!tx_ready && gap_n < 1000) gap_n++;
      else begin
        gap_on = 0;
        check("ipg_clocks", gap_n, 2 * CPB);
      end
    end
    prev_oe = usb_oe;
  end

  initial begin
    int unsigned n, offer;
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clock48);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_tx_error", tx_error, 1'b0);
    check("rst_dp_dn", {usb_dp_out, usb_dn_out}, 2'b10);
    check("rst_oe", usb_oe, 1'b0);
    reset_n = 1'b1;

    pkt[0] = 8'hD2;                        // ACK handshake
    send_pkt(1, 1);
    pkt[0] = 8'hC3; pkt[1] = 8'hFF; pkt[2] = 8'hFF;   // long runs of ones
    send_pkt(3, 3);
    pkt[0] = 8'hC3;                        // underrun right after PID
    send_pkt(3, 1);

    // Asynchronous reset in the middle of the PID data bits.
    @(negedge clock48);
    wait_idle();
    expect_abort = 1;
    tx_valid = 1'b1; tx_data = 8'hC3; tx_last = 1'b0;
    @(posedge clock48);
    @(negedge clock48);
    tx_valid = 1'b0;
    repeat (48) @(negedge clock48);
    #3 reset_n = 1'b0;
    #1;
    check("arst_oe", usb_oe, 1'b0);
    check("arst_dp_dn", {usb_dp_out, usb_dn_out}, 2'b10);
    check("arst_busy", tx_busy, 1'b0);
    repeat (2) @(negedge clock48);
    reset_n = 1'b1;
    @(negedge clock48);
    check("post_rst_ready", tx_ready, 1'b1);
    pkt[0] = 8'hD2;
    send_pkt(1, 1);

    pkt[0] = 8'h4B;                        // DATA1, empty payload
    send_pkt(1, 1);
    pkt[0] = 8'hC3; pkt[1] = 8'h00; pkt[2] = 8'h01; pkt[3] = 8'h02; pkt[4] = 8'h03;
    send_pkt(5, 5);

    pkt[0] = 8'hC3;                        // streaming 64-byte payload
    for (int unsigned i = 1; i < 65; i++) pkt[i] = 8'($urandom);
    send_pkt(65, 65);

    for (int unsigned p = 0; p < 25; p++) begin
      n = 1 + $urandom_range(0, 7);
      pkt[0][3:0] = 4'($urandom_range(0, 15));
      pkt[0][7:4] = ~pkt[0][3:0];
      for (int unsigned i = 1; i < n; i++)
        pkt[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      offer = (n > 1 && $urandom_range(0, 4) == 0) ? $urandom_range(1, n - 1) : n;
      send_pkt(n, offer);
    end

    for (int unsigned w = 0; w < 20000 && (exp_q.size() != 0 || gap_on || usb_oe); w++)
      @(negedge clock48);
    check("packets_outstanding", exp_q.size(), 0);
    check("spurious_pulses", spurious, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
